// File: rtl/uc_seq.sv
// uc_seq: sequenced control unit with I/O handshake, return-address stack tracking and sticky fault capture.
module uc_seq #(
  parameter int STACK_DEPTH = 8,
  parameter int IO_TIMEOUT = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [5:0]                           opcode,
  input  logic                                 z,
  input  logic                                 io_ack,
  output logic                                 s_inc,
  output logic                                 we3,
  output logic                                 wez,
  output logic                                 we_stack,
  output logic                                 s_jret,
  output logic                                 we_port,
  output logic [2:0]                           op_alu,
  output logic [1:0]                           sel_inputs,
  output logic                                 pc_en,
  output logic                                 io_req,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     sp,
  output logic                                 fault,
  output logic [1:0]                           fault_code
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  typedef enum logic [1:0] {S_EXEC, S_IO, S_FAULT} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [SPW-1:0] sp_nx;
  logic [1:0] code_nx;
  logic arith, ldi, jcc, jmp, op_in, op_out, jal, ret, full, empty;
  assign arith  = ~opcode[5];
  assign ldi    = opcode[5:2] == 4'b1000;
  assign jcc    = opcode[5:1] == 5'b10010;
  assign jmp    = opcode == 6'b100110;
  assign op_in  = opcode == 6'b100111;
  assign op_out = opcode == 6'b101000;
  assign jal    = opcode == 6'b101001;
  assign ret    = opcode == 6'b101010;
  assign full   = sp == SPW'(STACK_DEPTH);
  assign empty  = sp == '0;
  assign op_alu = opcode[4:2];
  always_comb begin
    s_inc = 1'b0;
    we3 = 1'b0;
    wez = 1'b0;
    we_stack = 1'b0;
    s_jret = 1'b0;
    we_port = 1'b0;
    sel_inputs = 2'b00;
    pc_en = 1'b0;
    io_req = 1'b0;
    state_nx = state;
    cnt_nx = cnt;
    sp_nx = sp;
    code_nx = fault_code;
    if (state == S_EXEC) begin
      if (arith) begin
        s_inc = 1'b1;
        we3 = 1'b1;
        wez = 1'b1;
        pc_en = 1'b1;
      end else if (ldi) begin
        s_inc = 1'b1;
        sel_inputs = 2'b11;
        we3 = 1'b1;
        pc_en = 1'b1;
      end else if (jcc) begin
        s_inc = z == opcode[0];
        pc_en = 1'b1;
      end else if (jmp) begin
        pc_en = 1'b1;
      end else if (op_in | op_out) begin
        state_nx = S_IO;
        cnt_nx = '0;
      end else if (jal & ~full) begin
        we_stack = 1'b1;
        pc_en = 1'b1;
        sp_nx = sp + SPW'(1);
      end else if (ret & ~empty) begin
        we_stack = 1'b1;
        s_jret = 1'b1;
        pc_en = 1'b1;
        sp_nx = sp - SPW'(1);
      end else begin
        state_nx = S_FAULT;
        code_nx = (jal | ret) ? 2'b10 : 2'b01;
      end
    end else if (state == S_IO) begin
      io_req = 1'b1;
      if (io_ack) begin
        we3 = op_in;
        sel_inputs = op_in ? 2'b01 : 2'b00;
        we_port = ~op_in;
        s_inc = 1'b1;
        pc_en = 1'b1;
        state_nx = S_EXEC;
      end else if (cnt == 8'(IO_TIMEOUT - 1)) begin
        state_nx = S_FAULT;
        code_nx = 2'b11;
      end else begin
        cnt_nx = cnt + 8'd1;
      end
    end
    // reset gates every strobe combinationally so a pending transfer dies at once
    if (!reset) begin
      s_inc = 1'b0;
      we3 = 1'b0;
      wez = 1'b0;
      we_stack = 1'b0;
      s_jret = 1'b0;
      we_port = 1'b0;
      sel_inputs = 2'b00;
      pc_en = 1'b0;
      io_req = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EXEC;
      cnt <= '0;
      sp <= '0;
      fault <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      sp <= sp_nx;
      fault <= state_nx == S_FAULT;
      fault_code <= code_nx;
    end
  end
endmodule

// File: tb/tb_uc_seq.sv
// tb_uc_seq: directed stimulus for uc_seq, checked every cycle against an instruction-level model plus literal spot checks.
module tb_uc_seq;
  localparam int DEPTH = 8;
  localparam int TMO = 16;
  logic clk, reset, z, io_ack;
  logic [5:0] opcode;
  logic s_inc, we3, wez, we_stack, s_jret, we_port, pc_en, io_req, fault;
  logic [2:0] op_alu;
  logic [1:0] sel_inputs, fault_code;
  logic [3:0] sp;
  logic [19:0] outs;
  int cmp_n = 0, cmp_ok = 0, lit_n = 0, lit_ok = 0;
  int m_st, m_sp, m_wait, m_code;

  uc_seq #(.STACK_DEPTH(DEPTH), .IO_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .io_ack(io_ack),
    .s_inc(s_inc), .we3(we3), .wez(wez), .we_stack(we_stack), .s_jret(s_jret),
    .we_port(we_port), .op_alu(op_alu), .sel_inputs(sel_inputs), .pc_en(pc_en),
    .io_req(io_req), .sp(sp), .fault(fault), .fault_code(fault_code)
  );

  assign outs = {s_inc, we3, wez, we_stack, s_jret, we_port, op_alu, sel_inputs, pc_en, io_req, sp, fault, fault_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction-level model: 0 = executing, 1 = waiting on port, 2 = faulted
  function automatic logic [19:0] model_out();
    logic inc = 0, w3 = 0, wz = 0, ws = 0, jr = 0, wp = 0, pe = 0, rq = 0;
    logic [1:0] sel = 2'b00;
    int op = int'(opcode);
    if (reset) begin
      if (m_st == 0) begin
        if (op < 32) begin inc = 1; w3 = 1; wz = 1; pe = 1; end
        else if (op < 36) begin inc = 1; w3 = 1; sel = 2'b11; pe = 1; end
        else if (op < 38) begin pe = 1; inc = !(z == !opcode[0]); end
        else if (op == 38) pe = 1;
        else if (op == 41 && m_sp < DEPTH) begin ws = 1; pe = 1; end
        else if (op == 42 && m_sp > 0) begin ws = 1; jr = 1; pe = 1; end
      end else if (m_st == 1) begin
        rq = 1;
        if (io_ack) begin
          inc = 1; pe = 1;
          if (op == 39) begin w3 = 1; sel = 2'b01; end
          else wp = 1;
        end
      end
    end
    return {inc, w3, wz, ws, jr, wp, opcode[4:2], sel, pe, rq, 4'(m_sp), m_st == 2, 2'(m_code)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st <= 0; m_sp <= 0; m_wait <= 0; m_code <= 0;
    end else if (m_st == 0) begin
      if (opcode == 6'd39 || opcode == 6'd40) begin m_st <= 1; m_wait <= 0; end
      else if (opcode == 6'd41) begin
        if (m_sp < DEPTH) m_sp <= m_sp + 1; else begin m_st <= 2; m_code <= 2; end
      end else if (opcode == 6'd42) begin
        if (m_sp > 0) m_sp <= m_sp - 1; else begin m_st <= 2; m_code <= 2; end
      end else if (opcode > 6'd42) begin m_st <= 2; m_code <= 1; end
    end else if (m_st == 1) begin
      if (io_ack) m_st <= 0;
      else if (m_wait + 1 == TMO) begin m_st <= 2; m_code <= 3; end
      else m_wait <= m_wait + 1;
    end
  end

  always @(negedge clk) begin
    logic [19:0] e;
    e = model_out();
    cmp_n++;
    if (outs === e) cmp_ok++;
    else $display("FAIL model t=%0t outs got %b exp %b", $time, outs, e);
  end

  task automatic lit(input string n, input logic [7:0] got, input logic [7:0] exp);
    lit_n++;
    if (got === exp) lit_ok++;
    else $display("FAIL %s got %0h exp %0h", n, got, exp);
  endtask

  task automatic cyc(input logic [5:0] op, input logic zz, input logic ack);
    @(posedge clk);
    #1 opcode = op; z = zz; io_ack = ack;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    cyc(6'd0, 1'b0, 1'b0);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; opcode = 6'd0; z = 1'b0; io_ack = 1'b0;
    cyc(6'd0, 0, 0);
    cyc(6'd0, 0, 0);
    lit("rst_ctl", {pc_en, we3, wez, io_req}, 8'h0);
    lit("rst_sp", 8'(sp), 8'd0);
    lit("rst_fault", {fault, fault_code}, 8'h0);
    #2 reset = 1'b1;
    cyc(6'b000101, 0, 0);
    lit("arith", {op_alu, we3, wez, s_inc, pc_en}, 8'b0011111);
    cyc(6'b100100, 1, 0);
    lit("jz_taken", {s_inc, pc_en}, 8'b01);
    cyc(6'b100101, 1, 0);
    lit("jnz_not_taken", {s_inc, pc_en}, 8'b11);
    cyc(6'b100011, 0, 0);
    lit("ldi", {sel_inputs, we3}, 8'b111);
    cyc(6'b100111, 0, 0);
    lit("in_issue", {pc_en, io_req, we3}, 8'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(6'b100111, 0, 0);
      lit("in_wait", {io_req, we3, pc_en}, 8'b100);
    end
    cyc(6'b100111, 0, 1);
    lit("in_ack", {io_req, we3, sel_inputs, pc_en}, 8'b11011);
    for (int i = 0; i < 9; i++) begin
      cyc(6'b101001, 0, 0);
      lit("jal_sp", 8'(sp), 8'(i));
      lit("jal_we", 8'(we_stack), (i < DEPTH) ? 8'd1 : 8'd0);
    end
    cyc(6'd0, 0, 0);
    lit("jal_ovf", {fault, fault_code, sp}, {1'b1, 2'b10, 4'd8});
    pulse_reset();
    cyc(6'b101010, 0, 0);
    lit("ret_empty_we", 8'(we_stack), 8'd0);
    cyc(6'd0, 0, 0);
    lit("ret_unf", {fault, fault_code, sp}, {1'b1, 2'b10, 4'd0});
    pulse_reset();
    cyc(6'b101000, 0, 0);
    for (int i = 0; i < TMO; i++) begin
      cyc(6'b101000, 0, 0);
      lit("out_wait", {we_port, fault, io_req}, 8'b001);
    end
    cyc(6'b101000, 0, 0);
    lit("out_tmo", {fault, fault_code, we_port, io_req}, 8'b11100);
    pulse_reset();
    cyc(6'b100111, 0, 0);
    cyc(6'b100111, 0, 0);
    lit("io_req_pre", 8'(io_req), 8'd1);
    #2 reset = 1'b0; io_ack = 1'b1;
    #1 lit("rst_in_io", {io_req, we3, pc_en}, 8'h0);
    cyc(6'd0, 0, 0);
    #2 reset = 1'b1;
    cyc(6'b110000, 0, 0);
    cyc(6'd0, 0, 0);
    lit("illegal", {fault, fault_code, pc_en}, 8'b1010);
    pulse_reset();
    lit("post_rst", {fault, sp}, 8'h0);
    cyc(6'b000001, 0, 0);
    lit("post_rst_exec", {we3, pc_en}, 8'b11);
    cyc(6'd0, 0, 0);
    $display("%0d/%0d checks passed", cmp_ok + lit_ok, cmp_n + lit_n);
    $finish;
  end
endmodule
